// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;
    typedef enum logic {OWN_P0, OWN_P1} owner_t;

    localparam int RD_LAT_MAX = 4;
    localparam int WAIT_W     = 4;
endpackage

// File: rtl/mem_arb_priority.sv
// Grant decision: port 0 has priority unless port 1 has waited MAX_WAIT cycles.
module mem_arb_priority
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              p0_req,
    input  logic              p1_req,
    input  logic [WAIT_W-1:0] wait_cnt,
    output logic              gnt_p0,
    output logic              gnt_p1
);
    logic starved;

    always_comb begin
        starved = (wait_cnt == WAIT_W'(MAX_WAIT));
        gnt_p1  = p1_req & (~p0_req | starved);
        gnt_p0  = p0_req & ~gnt_p1;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data memory between the MEM stage (port 0) and an
// auxiliary master (port 1); sequences multi-cycle reads and stalls port 0.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_stall,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rvalid,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int LAT_W = $clog2(RD_LAT_MAX + 1);

    state_t            state, state_nxt;
    owner_t            owner;
    logic [WAIT_W-1:0] wait_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic              gnt_p0, gnt_p1;
    logic              issue_p0, issue_p1, issue_rd, lat_done;

    mem_arb_priority #(.MAX_WAIT(MAX_WAIT)) u_priority (
        .p0_req   (p0_req),
        .p1_req   (p1_req),
        .wait_cnt (wait_cnt),
        .gnt_p0   (gnt_p0),
        .gnt_p1   (gnt_p1)
    );

    always_comb begin
        issue_p0  = (state == IDLE) & gnt_p0;
        issue_p1  = (state == IDLE) & gnt_p1;
        issue_rd  = (issue_p0 & ~p0_we) | (issue_p1 & ~p1_we);
        lat_done  = (state == RD_WAIT) & (lat_cnt == LAT_W'(RD_LAT));

        mem_en    = issue_p0 | issue_p1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue_p0) begin
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (issue_p1) begin
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end

        p1_gnt    = issue_p1;
        p0_rvalid = (state == RD_DONE) & (owner == OWN_P0);
        p1_rvalid = (state == RD_DONE) & (owner == OWN_P1);
        // Port 0 completes either on a granted write or in its own RD_DONE cycle.
        p0_stall  = p0_req & ~((issue_p0 & p0_we) | p0_rvalid);
        busy      = (state != IDLE);

        state_nxt = state;
        case (state)
            IDLE:    if (issue_rd) state_nxt = RD_WAIT;
            RD_WAIT: if (lat_done) state_nxt = RD_DONE;
            RD_DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= OWN_P0;
            wait_cnt <= '0;
            lat_cnt  <= '0;
        end else begin
            if (issue_rd) begin
                owner   <= issue_p1 ? OWN_P1 : OWN_P0;
                lat_cnt <= LAT_W'(1);
            end else if ((state == RD_WAIT) && !lat_done) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end

            // Counts how long port 1 has been losing; saturates so override persists.
            if (issue_p1)
                wait_cnt <= '0;
            else if (issue_p0 && p1_req && (wait_cnt != WAIT_W'(MAX_WAIT)))
                wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else if (lat_done) begin
            if (owner == OWN_P0) p0_rdata <= mem_rdata;
            else                 p1_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a shadow memory
// and transaction-level timing rules.
module tb_mem_port_arbiter;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic        p0_stall, p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic        p1_gnt, p1_rvalid;
    logic [31:0] p1_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem_arr [0:63] = '{default: 32'h0};
    logic [31:0] shadow  [0:63] = '{default: 32'h0};
    logic [31:0] rpipe   [0:RD_LAT-1];

    int passed = 0;
    int total  = 0;
    int cycle  = 0;
    int last_rv;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_stall(p0_stall), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory with RD_LAT-cycle read pipeline; junk when no read was issued.
    always @(posedge clk) begin
        cycle <= cycle + 1;
        rpipe[0] <= (mem_en && !mem_we) ? mem_arr[mem_addr[7:2]] : 32'hA5A5A5A5;
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
        if (mem_en && mem_we) mem_arr[mem_addr[7:2]] <= mem_wdata;
    end
    assign mem_rdata = rpipe[RD_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic p0_txn(input logic we, input logic [31:0] a, input logic [31:0] d);
        int n;
        p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d;
        #1;
        chk("p0_issue_en", 32'(mem_en), 32'd1);
        chk("p0_issue_we", 32'(mem_we), 32'(we));
        chk("p0_issue_addr", mem_addr, a);
        chk("p0_issue_wdata", mem_wdata, d);
        n = 0;
        while (p0_stall && n < 20) begin cyc(); n++; #1; end
        chk("p0_stall_cycles", n, we ? 32'd0 : 32'(RD_LAT + 1));
        if (!we) begin
            chk("p0_rvalid", 32'(p0_rvalid), 32'd1);
            chk("p0_rdata", p0_rdata, shadow[a[7:2]]);
            last_rv = cycle;
        end else begin
            shadow[a[7:2]] = d;
        end
        cyc();
        p0_req = 1'b0;
    endtask

    task automatic p1_txn(input logic we, input logic [31:0] a, input logic [31:0] d);
        int n;
        p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d;
        #1;
        n = 0;
        while (!p1_gnt && n < 20) begin cyc(); n++; #1; end
        chk("p1_gnt_wait", n, 32'd0);
        chk("p1_issue_addr", mem_addr, a);
        chk("p1_issue_we", 32'(mem_we), 32'(we));
        if (we) begin
            shadow[a[7:2]] = d;
        end else begin
            n = 0;
            while (!p1_rvalid && n < 20) begin cyc(); n++; #1; end
            chk("p1_rvalid_lat", n, 32'(RD_LAT + 1));
            chk("p1_rdata", p1_rdata, shadow[a[7:2]]);
        end
        cyc();
        p1_req = 1'b0;
    endtask

    initial begin
        logic [31:0] a, d;
        int sp;

        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'd0);
        chk("rst_p1_rdata", p1_rdata, 32'd0);
        chk("rst_rvalid", 32'({p0_rvalid, p1_rvalid, p1_gnt}), 32'd0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // Single port-0 write
        p0_txn(1'b1, 32'h10, 32'hDEADBEEF);
        #1;
        chk("idle_mem_en", 32'(mem_en), 32'd0);
        chk("idle_mem_addr", mem_addr, 32'd0);
        chk("idle_p0_stall", 32'(p0_stall), 32'd0);
        cyc();

        // Port-1 write then port-0 read of it
        p1_txn(1'b1, 32'h20, 32'h12345678);
        p0_txn(1'b0, 32'h20, 32'h0);
        #1;
        chk("rd_rvalid_drop", 32'(p0_rvalid), 32'd0);
        chk("rd_rdata_hold", p0_rdata, 32'h12345678);
        cyc();

        // Contention with writes: port 1 wins after MAX_WAIT losses
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h30; p0_wdata = 32'h1;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h34; p1_wdata = 32'h2;
        for (int i = 0; i < MAX_WAIT; i++) begin
            #1;
            chk("cont_p0_win_stall", 32'(p0_stall), 32'd0);
            chk("cont_p0_win_gnt1", 32'(p1_gnt), 32'd0);
            chk("cont_p0_win_addr", mem_addr, 32'h30);
            cyc();
        end
        #1;
        chk("cont_p1_gnt", 32'(p1_gnt), 32'd1);
        chk("cont_p0_stall", 32'(p0_stall), 32'd1);
        chk("cont_p1_addr", mem_addr, 32'h34);
        chk("cont_p1_wdata", mem_wdata, 32'h2);
        cyc();
        p1_req = 1'b0;
        #1;
        chk("cont_after_stall", 32'(p0_stall), 32'd0);
        cyc();
        p1_req = 1'b1;
        #1;
        chk("cont_cleared_gnt1", 32'(p1_gnt), 32'd0);
        chk("cont_cleared_stall", 32'(p0_stall), 32'd0);
        cyc();
        p0_req = 1'b0; p1_req = 1'b0;
        shadow[12] = 32'h1; shadow[13] = 32'h2;
        cyc();

        // Port-1 read in flight blocks a port-0 write
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h10;
        #1;
        chk("p1rd_gnt", 32'(p1_gnt), 32'd1);
        cyc();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h38; p0_wdata = 32'h3;
        for (int k = 0; k <= RD_LAT; k++) begin
            #1;
            chk("p1rd_p0_stall", 32'(p0_stall), 32'd1);
            chk("p1rd_mem_en", 32'(mem_en), 32'd0);
            if (k == RD_LAT) begin
                chk("p1rd_rvalid", 32'(p1_rvalid), 32'd1);
                chk("p1rd_rdata", p1_rdata, 32'hDEADBEEF);
            end
            cyc();
        end
        p1_req = 1'b0;
        #1;
        chk("p1rd_p0_go_stall", 32'(p0_stall), 32'd0);
        chk("p1rd_p0_go_en", 32'(mem_en), 32'd1);
        chk("p1rd_p0_go_addr", mem_addr, 32'h38);
        chk("p1rd_rvalid_drop", 32'(p1_rvalid), 32'd0);
        cyc();
        p0_req = 1'b0;
        shadow[14] = 32'h3;
        cyc();

        // Reset aborts a port-0 read in RD_WAIT
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
        cyc();
        #1;
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1; p0_req = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        chk("abort_p0_rdata", p0_rdata, 32'd0);
        chk("abort_p1_rdata", p1_rdata, 32'd0);
        chk("abort_stall", 32'(p0_stall), 32'd0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < RD_LAT + 3; i++) begin
            #1;
            chk("abort_no_rvalid", 32'({p0_rvalid, busy}), 32'd0);
            cyc();
        end

        // Back-to-back port-0 reads
        p0_txn(1'b1, 32'h0, 32'hA0A00001);
        p0_txn(1'b1, 32'h4, 32'hB0B00002);
        p0_txn(1'b0, 32'h0, 32'h0);
        sp = last_rv;
        p0_txn(1'b0, 32'h4, 32'h0);
        chk("b2b_rvalid_spacing", 32'(last_rv - sp), 32'(RD_LAT + 2));

        // Randomized single-requester transactions
        for (int t = 0; t < 40; t++) begin
            a = $urandom;
            a[1:0] = 2'b00;
            d = $urandom;
            if ($urandom_range(0, 1) == 0) p0_txn(1'($urandom_range(0, 1)), a, d);
            else                           p1_txn(1'($urandom_range(0, 1)), a, d);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single-port 32-bit data memory between two requesters: the pipeline MEM stage (port 0) and an auxiliary master such as a program loader or DMA (port 1).
- Sits between the EX/MEM pipeline register outputs and the data memory.
- Sequences multi-cycle reads.
- Drives a stall back to the pipeline so the EX/MEM register holds until the port-0 access completes.

Parameters:
- ADDR_W, 32, memory address width (port 0 drives its ALU result).
- DATA_W, 32, data width.
- RD_LAT, 1, memory read latency in cycles after the issuing edge; legal range 1..4.
- MAX_WAIT, 4, number of consecutive losing IDLE cycles after which port 1 overrides port-0 priority; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- p0_req  in  1  MEM-stage access valid (mem_write OR mem_to_reg)
- p0_we  in  1  1 = write, 0 = read
- p0_addr  in  ADDR_W  address
- p0_wdata  in  DATA_W  write data (RD2)
- p0_stall  out  1  hold pipeline; port-0 access not completing this cycle
- p0_rdata  out  DATA_W  registered read data
- p0_rvalid  out  1  port-0 read data valid, one-cycle pulse
- p1_req  in  1  auxiliary request; must hold req/we/addr/wdata stable until completion
- p1_we  in  1  1 = write
- p1_addr  in  ADDR_W  address
- p1_wdata  in  DATA_W  write data
- p1_gnt  out  1  one-cycle pulse in the issue cycle
- p1_rdata  out  DATA_W  registered read data
- p1_rvalid  out  1  port-1 read data valid, one-cycle pulse
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in cycle issue+RD_LAT
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: FSM→IDLE, owner→P0, wait_cnt→0, lat_cnt→0.
  - p0_rdata = p1_rdata = 0; p0_rvalid = p1_rvalid = p1_gnt = 0.
  - mem_en = mem_we = 0; busy = 0.
  - An asserted rst aborts any in-flight read; no rvalid is ever produced for it.
- FSM states: IDLE, RD_WAIT, RD_DONE.
- IDLE arbitration (combinational):
  - Only p0_req → grant P0. Only p1_req → grant P1.
  - Both → grant P0, unless wait_cnt == MAX_WAIT, then grant P1.
  - Granted port drives mem_en = 1 and its own we/addr/wdata onto the mem_* outputs in the same cycle (the issue cycle). No grant → mem_en = 0; mem_* data outputs = 0.
- Write issue:
  - Completes in the issue cycle; FSM stays IDLE.
  - P0 write: p0_stall = 0 that cycle. P1 write: p1_gnt = 1.
- Read issue:
  - Record owner; lat_cnt→1; FSM→RD_WAIT. P1 read: p1_gnt = 1.
- RD_WAIT:
  - mem_en = 0. At a clock edge with lat_cnt == RD_LAT: capture mem_rdata into the owner's rdata register and go to RD_DONE. Otherwise lat_cnt increments.
- RD_DONE:
  - Owner's rvalid = 1 for exactly one cycle; no new issue; next state IDLE.
- Read timing: issue at cycle T, capture at the end of T+RD_LAT, rvalid at T+RD_LAT+1.
- rdata holding: rdata registers hold their value until that port's next read capture.
- p0_stall:
  - = p0_req AND NOT (P0 write granted this cycle OR (RD_DONE AND owner == P0)).
  - A port-0 read therefore stalls RD_LAT+1 cycles.
  - p0_stall is also high while P1 owns a read and p0_req = 1.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, in each IDLE cycle with p1_req = 1 and P0 granted.
  - Clears on any P1 grant; unchanged outside IDLE.
- Port 1 deassert: p1_req falling before completion is illegal; no requirement on the result.
- Address: no range checks; mem_addr passes through unmodified.

Decomposition:
- Package mem_arb_pkg:
  - state_t enum {IDLE, RD_WAIT, RD_DONE}; owner_t enum {OWN_P0, OWN_P1}.
  - Constants RD_LAT_MAX = 4 and WAIT_W = 4.
- Sub-module mem_arb_priority: combinational grant decision (p0_req, p1_req, wait_cnt, MAX_WAIT → gnt_p0, gnt_p1).
- The FSM, counters and data registers stay in the top module.

Test Plan:
- Reset, then a single P0 write to addr 0x10 with data 0xDEADBEEF → mem_en = mem_we = 1 in the same cycle with that addr/data, and p0_stall = 0 throughout.
- RD_LAT = 2, P0 read of addr 0x20 with memory returning 0x12345678 → p0_stall high for 3 cycles; p0_rvalid pulses at T+3 with p0_rdata = 0x12345678; p0_rdata held afterwards.
- p0_req and p1_req both held continuously (writes), MAX_WAIT = 4 → P0 wins 4 cycles, P1 wins the 5th (p1_gnt = 1, p0_stall = 1), wait_cnt = 0 afterwards.
- P1 read in flight (RD_WAIT) when a P0 write arrives → P0 stalled and mem_en = 0 until after P1's RD_DONE; the P0 write issues in the following IDLE cycle.
- Assert rst during RD_WAIT of a P0 read → all outputs return to reset values asynchronously; no p0_rvalid occurs after reset release.
- RD_LAT = 1, back-to-back P0 reads to 0x0 then 0x4 → each stalls 2 cycles; rvalid pulses 3 cycles apart with the correct data for each.
